// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and types for the instruction-fetch stage.
//   RESET_PC    - PC loaded on reset
//   NOP_INSTR   - bubble instruction placed in IF/ID when it is flushed or empty
//   fetch_state_e - fetch controller states
//   ifid_t      - one IF/ID (or skid) entry: instruction, PC+2, valid
package fetch_stage_pkg;

   localparam logic [15:0] RESET_PC  = 16'h0000;
   localparam logic [15:0] NOP_INSTR = 16'h0800;

   typedef enum logic [2:0] {
      StFetch,
      StWait,
      StDrain,
      StHold,
      StHalted
   } fetch_state_e;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc_2;
      logic        valid;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_2: 16'h0000, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: pipeline/cache signals of the fetch stage.
//   master (fetch stage): drives imem_addr, imem_rd, IF_instr, IF_pc_2, IF_valid, fetch_busy;
//                         receives redirect, redirect_pc, stall, halt, imem_data, imem_done.
//   slave (decode/execute/cache side): the mirror image.
interface fetch_stage_if;

   logic        redirect;
   logic [15:0] redirect_pc;
   logic        stall;
   logic        halt;
   logic [15:0] imem_addr;
   logic        imem_rd;
   logic [15:0] imem_data;
   logic        imem_done;
   logic [15:0] IF_instr;
   logic [15:0] IF_pc_2;
   logic        IF_valid;
   logic        fetch_busy;

   modport master (
      input  redirect, redirect_pc, stall, halt, imem_data, imem_done,
      output imem_addr, imem_rd, IF_instr, IF_pc_2, IF_valid, fetch_busy
   );

   modport slave (
      output redirect, redirect_pc, stall, halt, imem_data, imem_done,
      input  imem_addr, imem_rd, IF_instr, IF_pc_2, IF_valid, fetch_busy
   );

endinterface

// File: rtl/fetch_stage_cla16.sv
// fetch_stage_cla16: 16-bit carry-lookahead adder (four 4-bit groups, lookahead across groups).
//   a, b  in  16  operands
//   cin   in  1   carry in
//   sign  in  1   1: ovf reports signed overflow, 0: ovf reports unsigned carry out
//   sum   out 16  a + b + cin, modulo 2^16
//   cout  out 1   carry out of bit 15
//   ovf   out 1   overflow per sign
module fetch_stage_cla16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   input  logic        sign,
   output logic [15:0] sum,
   output logic        cout,
   output logic        ovf
);

   logic [15:0] g;
   logic [15:0] p;
   logic [16:0] c;
   logic [3:0]  grp_g;
   logic [3:0]  grp_p;
   logic [4:0]  grp_c;

   always_comb begin
      g = a & b;
      p = a ^ b;
      for (int k = 0; k < 4; k++) begin
         grp_g[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         grp_p[k] = &p[4*k +: 4];
      end
      grp_c[0] = cin;
      for (int k = 0; k < 4; k++) begin
         grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
      end
      c = '0;
      for (int k = 0; k < 4; k++) begin
         c[4*k] = grp_c[k];
         for (int j = 0; j < 3; j++) begin
            c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
         end
      end
      c[16] = grp_c[4];
   end

   assign sum  = p ^ c[15:0];
   assign cout = c[16];
   assign ovf  = sign ? (c[16] ^ c[15]) : c[16];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with IF/ID register, one-entry skid buffer and redirect/halt.
//   clk  in  system clock (rising edge)
//   rst  in  asynchronous active-high reset
//   bus  fetch_stage_if.master: redirect/redirect_pc, stall, halt from the pipeline;
//        imem_addr/imem_rd/imem_data/imem_done to the I-cache; IF_instr/IF_pc_2/IF_valid
//        to decode; fetch_busy high while a miss is outstanding (WAIT or DRAIN).
module fetch_stage
   import fetch_stage_pkg::*;
(
   input logic           clk,
   input logic           rst,
   fetch_stage_if.master bus
);

   fetch_state_e state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic [15:0]  redir_pc_q, redir_pc_d;
   logic         drain_halt_q, drain_halt_d;
   ifid_t        ifid_q, ifid_d;
   ifid_t        skid_q, skid_d;

   logic [15:0]  pc_2;
   logic         unused_cout;
   logic         unused_ovf;
   logic         ifid_free;
   logic         imem_rd;
   ifid_t        fetched;

   fetch_stage_cla16 u_pc_add (
      .a    (pc_q),
      .b    (16'h0002),
      .cin  (1'b0),
      .sign (1'b0),
      .sum  (pc_2),
      .cout (unused_cout),
      .ovf  (unused_ovf)
   );

   always_comb begin
      ifid_free    = !bus.stall || !ifid_q.valid;
      fetched      = '{instr: bus.imem_data, pc_2: pc_2, valid: 1'b1};
      state_d      = state_q;
      pc_d         = pc_q;
      redir_pc_d   = redir_pc_q;
      drain_halt_d = drain_halt_q;
      ifid_d       = ifid_q;
      skid_d       = skid_q;
      imem_rd      = 1'b0;

      unique case (state_q)
         StFetch: begin
            // A redirect or halt would discard the returned word, so no request is made.
            imem_rd = ifid_free && !bus.redirect && !bus.halt;
            if (bus.redirect) begin
               pc_d   = bus.redirect_pc;
               ifid_d = IFID_BUBBLE;
               skid_d = IFID_BUBBLE;
            end else if (bus.halt) begin
               state_d = StHalted;
            end else if (bus.imem_done && ifid_free) begin
               ifid_d = fetched;
               pc_d   = pc_2;
            end else begin
               // Also covers a stalled, full IF/ID: the request is issued from WAIT so the
               // word can land in the skid buffer.
               if (ifid_free) ifid_d = IFID_BUBBLE;
               state_d = StWait;
            end
         end
         StWait: begin
            imem_rd = 1'b1;
            if (bus.redirect || bus.halt) begin
               if (bus.redirect) ifid_d = IFID_BUBBLE;
               if (bus.imem_done) begin
                  // Miss finished this very cycle: nothing left to drain.
                  if (bus.redirect) begin
                     pc_d    = bus.redirect_pc;
                     state_d = StFetch;
                  end else begin
                     state_d = StHalted;
                  end
               end else begin
                  redir_pc_d   = bus.redirect_pc;
                  drain_halt_d = !bus.redirect;
                  state_d      = StDrain;
               end
            end else if (bus.imem_done) begin
               pc_d = pc_2;
               if (ifid_free) begin
                  ifid_d  = fetched;
                  state_d = StFetch;
               end else begin
                  skid_d  = fetched;
                  state_d = StHold;
               end
            end else if (ifid_free) begin
               ifid_d = IFID_BUBBLE;
            end
         end
         StDrain: begin
            // Keep the abandoned request alive until the cache completes it.
            imem_rd = 1'b1;
            if (bus.redirect) begin
               redir_pc_d   = bus.redirect_pc;
               drain_halt_d = 1'b0;
               ifid_d       = IFID_BUBBLE;
            end
            if (bus.imem_done) begin
               if (drain_halt_d) begin
                  state_d = StHalted;
               end else begin
                  pc_d    = redir_pc_d;
                  state_d = StFetch;
               end
            end
         end
         StHold: begin
            if (bus.redirect) begin
               pc_d    = bus.redirect_pc;
               ifid_d  = IFID_BUBBLE;
               skid_d  = IFID_BUBBLE;
               state_d = StFetch;
            end else if (bus.halt) begin
               skid_d  = IFID_BUBBLE;
               state_d = StHalted;
            end else if (!bus.stall) begin
               ifid_d  = skid_q;
               skid_d  = IFID_BUBBLE;
               state_d = StFetch;
            end
         end
         StHalted: begin
            if (bus.redirect) begin
               pc_d    = bus.redirect_pc;
               ifid_d  = IFID_BUBBLE;
               skid_d  = IFID_BUBBLE;
               state_d = StFetch;
            end
         end
         default: begin
            state_d = StFetch;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StFetch;
         pc_q         <= RESET_PC;
         redir_pc_q   <= RESET_PC;
         drain_halt_q <= 1'b0;
         ifid_q       <= IFID_BUBBLE;
         skid_q       <= IFID_BUBBLE;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         redir_pc_q   <= redir_pc_d;
         drain_halt_q <= drain_halt_d;
         ifid_q       <= ifid_d;
         skid_q       <= skid_d;
      end
   end

   assign bus.imem_addr  = pc_q;
   assign bus.imem_rd    = imem_rd;
   assign bus.IF_instr   = ifid_q.instr;
   assign bus.IF_pc_2    = ifid_q.pc_2;
   assign bus.IF_valid   = ifid_q.valid;
   assign bus.fetch_busy = (state_q == StWait) || (state_q == StDrain);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. The cache returns addr ^ 16'h5A00.
// A behavioural model (PC, miss/drain flags, skid queue) is compared against every output
// each cycle, and hand-computed literals pin key points of each scenario.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_stage_if bus ();

   fetch_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.imem_data = bus.imem_addr ^ 16'h5A00;

   int errors = 0;
   int checks = 0;

   // Model state
   logic [15:0] m_pc;
   logic [15:0] m_target;
   bit          m_miss;
   bit          m_drain;
   bit          m_drain_halt;
   bit          m_halted;
   logic [15:0] m_instr;
   logic [15:0] m_pc_2;
   bit          m_valid;
   logic [15:0] q_instr[$];
   logic [15:0] q_pc_2[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 16'h0000; m_target = 16'h0000;
      m_miss = 0; m_drain = 0; m_drain_halt = 0; m_halted = 0;
      m_instr = 16'h0800; m_pc_2 = 16'h0000; m_valid = 0;
      q_instr.delete(); q_pc_2.delete();
   endtask

   function automatic bit m_rd();
      if (m_halted || q_instr.size() != 0) return 1'b0;
      if (m_miss || m_drain) return 1'b1;
      return !bus.redirect && !bus.halt && (!bus.stall || !m_valid);
   endfunction

   task automatic bubble();
      m_instr = 16'h0800; m_pc_2 = 16'h0000; m_valid = 0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      bit          free = !bus.stall || !m_valid;
      logic [15:0] word = m_pc ^ 16'h5A00;
      logic [15:0] nxt  = m_pc + 16'd2;
      if (bus.redirect) begin
         bubble();
         if (m_miss || m_drain) begin
            m_miss = 0; m_drain_halt = 0;
            if (bus.imem_done) begin
               m_drain = 0; m_pc = bus.redirect_pc;
            end else begin
               m_drain = 1; m_target = bus.redirect_pc;
            end
         end else begin
            m_pc = bus.redirect_pc; m_halted = 0;
            q_instr.delete(); q_pc_2.delete();
         end
      end else if (m_drain) begin
         if (bus.imem_done) begin
            m_drain = 0;
            if (m_drain_halt) m_halted = 1;
            else m_pc = m_target;
         end
      end else if (m_halted) begin
         m_halted = 1;
      end else if (bus.halt) begin
         q_instr.delete(); q_pc_2.delete();
         if (m_miss && !bus.imem_done) begin
            m_miss = 0; m_drain = 1; m_drain_halt = 1;
         end else begin
            m_miss = 0; m_halted = 1;
         end
      end else if (q_instr.size() != 0) begin
         if (!bus.stall) begin
            m_instr = q_instr.pop_front(); m_pc_2 = q_pc_2.pop_front(); m_valid = 1;
         end
      end else if (bus.imem_done && free) begin
         m_instr = word; m_pc_2 = nxt; m_valid = 1; m_pc = nxt; m_miss = 0;
      end else if (bus.imem_done && m_miss) begin
         q_instr.push_back(word); q_pc_2.push_back(nxt); m_pc = nxt; m_miss = 0;
      end else begin
         if (free) bubble();
         m_miss = 1;
      end
   endtask

   task automatic compare_all();
      check("imem_addr", bus.imem_addr, m_pc);
      check("imem_rd", {15'd0, bus.imem_rd}, {15'd0, m_rd()});
      check("fetch_busy", {15'd0, bus.fetch_busy}, {15'd0, m_miss || m_drain});
      check("IF_instr", bus.IF_instr, m_instr);
      check("IF_pc_2", bus.IF_pc_2, m_pc_2);
      check("IF_valid", {15'd0, bus.IF_valid}, {15'd0, m_valid});
   endtask

   // One clock: apply inputs, compare mid-cycle, step the model, return just after the edge.
   task automatic cyc(input bit redir, input logic [15:0] rpc, input bit stl, input bit hlt,
                      input bit dn);
      bus.redirect = redir; bus.redirect_pc = rpc; bus.stall = stl; bus.halt = hlt;
      bus.imem_done = dn;
      @(negedge clk);
      compare_all();
      model_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.redirect = 0; bus.redirect_pc = 16'h0000; bus.stall = 0; bus.halt = 0;
      bus.imem_done = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_IF_instr", bus.IF_instr, 16'h0800);
      check("rst_IF_pc_2", bus.IF_pc_2, 16'h0000);
      check("rst_IF_valid", {15'd0, bus.IF_valid}, 16'h0000);
      check("rst_fetch_busy", {15'd0, bus.fetch_busy}, 16'h0000);
      check("rst_imem_addr", bus.imem_addr, 16'h0000);
      check("rst_imem_rd", {15'd0, bus.imem_rd}, 16'h0001);

      // Back-to-back hits: IF_pc_2 = 2,4,6,8
      for (int i = 0; i < 4; i++) begin
         cyc(0, 16'h0, 0, 0, 1);
         check("hit_pc_2", bus.IF_pc_2, 16'(2 * (i + 1)));
         check("hit_valid", {15'd0, bus.IF_valid}, 16'h0001);
      end
      for (int i = 0; i < 4; i++) cyc(0, 16'h0, 0, 0, 1);
      check("pc_0x10", bus.imem_addr, 16'h0010);

      // Five-cycle miss at 0x0010
      cyc(0, 16'h0, 0, 0, 0);
      check("miss_busy", {15'd0, bus.fetch_busy}, 16'h0001);
      for (int i = 0; i < 3; i++) cyc(0, 16'h0, 0, 0, 0);
      check("miss_addr_stable", bus.imem_addr, 16'h0010);
      cyc(0, 16'h0, 0, 0, 1);
      check("miss_instr", bus.IF_instr, 16'h5A10);
      check("miss_pc_2", bus.IF_pc_2, 16'h0012);
      check("miss_busy_done", {15'd0, bus.fetch_busy}, 16'h0000);

      // Stall across a miss: word goes to the skid buffer, then into IF/ID exactly once
      cyc(0, 16'h0, 1, 0, 0);
      cyc(0, 16'h0, 1, 0, 0);
      cyc(0, 16'h0, 1, 0, 1);
      check("hold_ifid_kept", bus.IF_pc_2, 16'h0012);
      check("hold_rd", {15'd0, bus.imem_rd}, 16'h0000);
      cyc(0, 16'h0, 0, 0, 0);
      check("skid_instr", bus.IF_instr, 16'h5A12);
      check("skid_pc_2", bus.IF_pc_2, 16'h0014);
      check("skid_next_addr", bus.imem_addr, 16'h0014);
      cyc(0, 16'h0, 0, 0, 1);
      check("after_skid_pc_2", bus.IF_pc_2, 16'h0016);

      // Redirect during WAIT: drain the stale word, then fetch 0x0100
      cyc(0, 16'h0, 0, 0, 0);
      cyc(1, 16'h0100, 0, 0, 0);
      check("drain_busy", {15'd0, bus.fetch_busy}, 16'h0001);
      check("drain_old_addr", bus.imem_addr, 16'h0016);
      cyc(0, 16'h0, 0, 0, 0);
      cyc(0, 16'h0, 0, 0, 1);
      check("drain_target", bus.imem_addr, 16'h0100);
      check("drain_valid", {15'd0, bus.IF_valid}, 16'h0000);
      cyc(0, 16'h0, 0, 0, 0);
      cyc(0, 16'h0, 0, 0, 1);
      check("redir_instr", bus.IF_instr, 16'h5B00);
      check("redir_pc_2", bus.IF_pc_2, 16'h0102);

      // Halt then redirect to 0x0040
      for (int i = 0; i < 3; i++) begin
         cyc(0, 16'h0, 0, 1, 0);
         check("halt_rd", {15'd0, bus.imem_rd}, 16'h0000);
      end
      check("halt_pc_frozen", bus.imem_addr, 16'h0102);
      cyc(1, 16'h0040, 0, 1, 0);
      check("unhalt_addr", bus.imem_addr, 16'h0040);
      cyc(0, 16'h0, 0, 0, 1);
      check("unhalt_pc_2", bus.IF_pc_2, 16'h0042);

      // Redirect and stall together: flush wins
      cyc(1, 16'h0200, 1, 0, 0);
      check("flush_valid", {15'd0, bus.IF_valid}, 16'h0000);
      check("flush_instr", bus.IF_instr, 16'h0800);
      check("flush_addr", bus.imem_addr, 16'h0200);

      // Halt during a miss: drain, then HALTED
      cyc(0, 16'h0, 0, 0, 0);
      cyc(0, 16'h0, 0, 1, 0);
      cyc(0, 16'h0, 0, 0, 0);
      check("halt_drain_busy", {15'd0, bus.fetch_busy}, 16'h0001);
      cyc(0, 16'h0, 0, 0, 1);
      check("halt_drain_done", {15'd0, bus.fetch_busy}, 16'h0000);
      check("halt_drain_rd", {15'd0, bus.imem_rd}, 16'h0000);

      // Wrap at 0xFFFE
      cyc(1, 16'hFFFE, 0, 0, 0);
      cyc(0, 16'h0, 0, 0, 1);
      check("wrap_pc_2", bus.IF_pc_2, 16'h0000);
      check("wrap_instr", bus.IF_instr, 16'hA5FE);
      check("wrap_addr", bus.imem_addr, 16'h0000);

      // Reset in the middle of a miss
      cyc(0, 16'h0, 0, 0, 0);
      rst = 1'b1;
      #2;
      check("rst_mid_busy", {15'd0, bus.fetch_busy}, 16'h0000);
      check("rst_mid_valid", {15'd0, bus.IF_valid}, 16'h0000);
      check("rst_mid_addr", bus.imem_addr, 16'h0000);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      cyc(0, 16'h0, 0, 0, 1);
      check("post_rst_pc_2", bus.IF_pc_2, 16'h0002);
      cyc(0, 16'h0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
